// File: rtl/axis_header_insert_arbiter.sv
// Round-robin arbiter that feeds the header-insert port of an AXI-Stream
// header inserter. It grants one header per packet and holds the grant until
// the inserter's output stream completes that packet, then rotates priority.
module axis_header_insert_arbiter #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ID_WD        = $clog2(NUM_REQ),
    parameter int unsigned CNT_WD       = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ*DATA_WD-1:0]      req_header_i,
    input  logic [NUM_REQ*DATA_BYTE_WD-1:0] req_keep_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    output logic                            ins_valid_o,
    output logic [DATA_WD-1:0]              ins_header_o,
    output logic [DATA_BYTE_WD-1:0]         ins_keep_o,
    input  logic                            ins_ready_i,
    input  logic                            mon_valid_i,
    input  logic                            mon_ready_i,
    input  logic                            mon_last_i,
    output logic [ID_WD-1:0]                grant_id_o,
    output logic                            busy_o,
    output logic [CNT_WD-1:0]               pkt_cnt_o,
    output logic                            err_orphan_last_o
);

    typedef enum logic [1:0] {StIdle, StOffer, StBusy} state_e;

    state_e                  state_q, state_d;
    logic [ID_WD-1:0]        ptr_q, ptr_d;
    logic [ID_WD-1:0]        grant_id_q, grant_id_d;
    logic [DATA_WD-1:0]      hdr_q, hdr_d;
    logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
    logic [CNT_WD-1:0]       cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic [DATA_WD-1:0]      hdr_arr  [NUM_REQ];
    logic [DATA_BYTE_WD-1:0] keep_arr [NUM_REQ];
    logic [ID_WD-1:0]        next_ptr;
    logic [ID_WD-1:0]        base;
    logic [ID_WD-1:0]        win;
    logic                    found;
    logic                    grant;
    logic                    last_hs;

    // Unpack the flat requester buses into per-requester views.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            hdr_arr[i]  = req_header_i[i*DATA_WD +: DATA_WD];
            keep_arr[i] = req_keep_i[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        end
    end

    assign next_ptr = (grant_id_q == ID_WD'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
    assign last_hs  = mon_valid_i & mon_ready_i & mon_last_i;

    // Round-robin search upward from the base pointer with wrap. On packet
    // completion the rotated pointer is used so back-to-back grants are fair.
    always_comb begin
        int unsigned      sum;
        logic [ID_WD-1:0] idx;
        base  = (state_q == StBusy) ? next_ptr : ptr_q;
        found = 1'b0;
        win   = '0;
        sum   = 0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = (32'(base) + k) % NUM_REQ;
            idx = ID_WD'(sum);
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state logic: grant/capture, offer handshake, completion tracking.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        hdr_d      = hdr_q;
        keep_d     = keep_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        grant      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (last_hs) err_d = 1'b1;
                if (found) grant = 1'b1;
            end
            StOffer: begin
                if (last_hs) err_d = 1'b1;
                if (ins_ready_i) state_d = StBusy;
            end
            StBusy: begin
                if (last_hs) begin
                    cnt_d = cnt_q + 1'b1;
                    ptr_d = next_ptr;
                    if (found) grant = 1'b1;
                    else       state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (grant) begin
            hdr_d      = hdr_arr[win];
            keep_d     = keep_arr[win];
            grant_id_d = win;
            state_d    = StOffer;
        end
    end

    // Accept pulse is combinational; forced low while reset is held.
    always_comb begin
        req_ready_o = '0;
        if (grant && !rst) req_ready_o = NUM_REQ'(1) << win;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            grant_id_q <= '0;
            hdr_q      <= '0;
            keep_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            hdr_q      <= hdr_d;
            keep_q     <= keep_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign ins_valid_o       = (state_q == StOffer);
    assign ins_header_o      = hdr_q;
    assign ins_keep_o        = keep_q;
    assign grant_id_o        = grant_id_q;
    assign busy_o            = (state_q != StIdle);
    assign pkt_cnt_o         = cnt_q;
    assign err_orphan_last_o = err_q;

endmodule

// File: tb/tb_axis_header_insert_arbiter.sv
// Directed testbench for axis_header_insert_arbiter (4 requesters, 32-bit).
module tb_axis_header_insert_arbiter;

    localparam int DW = 32;
    localparam int BW = 4;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_header;
    logic [NR*BW-1:0] req_keep;
    logic [NR-1:0]    req_ready;
    logic             ins_valid;
    logic [DW-1:0]    ins_header;
    logic [BW-1:0]    ins_keep;
    logic             ins_ready;
    logic             mon_valid;
    logic             mon_ready;
    logic             mon_last;
    logic [IW-1:0]    grant_id;
    logic             busy;
    logic [CW-1:0]    pkt_cnt;
    logic             err_orphan_last;

    int checks = 0;
    int fails  = 0;

    axis_header_insert_arbiter #(
        .DATA_WD(DW), .DATA_BYTE_WD(BW), .NUM_REQ(NR), .ID_WD(IW), .CNT_WD(CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_i      (req_valid),
        .req_header_i     (req_header),
        .req_keep_i       (req_keep),
        .req_ready_o      (req_ready),
        .ins_valid_o      (ins_valid),
        .ins_header_o     (ins_header),
        .ins_keep_o       (ins_keep),
        .ins_ready_i      (ins_ready),
        .mon_valid_i      (mon_valid),
        .mon_ready_i      (mon_ready),
        .mon_last_i       (mon_last),
        .grant_id_o       (grant_id),
        .busy_o           (busy),
        .pkt_cnt_o        (pkt_cnt),
        .err_orphan_last_o(err_orphan_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hdr(input int i, input logic [DW-1:0] h, input logic [BW-1:0] k);
        req_header[i*DW +: DW] = h;
        req_keep[i*BW +: BW]   = k;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        req_header = '0;
        req_keep   = '0;
        ins_ready  = 1'b0;
        mon_valid  = 1'b0;
        mon_ready  = 1'b0;
        mon_last   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [NR+1+DW+BW+IW+1+CW+1-1:0] outs;
        rst        = 1'b1;
        req_header = '0;
        req_keep   = '0;
        ins_ready  = 1'b0;
        mon_valid  = 1'b0;
        mon_ready  = 1'b0;
        mon_last   = 1'b0;
        req_valid  = 4'hF;
        #3;
        outs = {req_ready, ins_valid, ins_header, ins_keep, grant_id, busy, pkt_cnt,
                err_orphan_last};
        checks++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL reset_outputs got=%0h exp=0", outs);
        end
        req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_hdr(1, 32'hFFEE_DDCC, 4'b0111);
        req_valid = 4'b0010;
        ins_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            fails++;
            $display("FAIL single_req_ready got=%b exp=0010", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if ({ins_valid, ins_header, ins_keep, grant_id, req_ready} !==
            {1'b1, 32'hFFEE_DDCC, 4'b0111, 2'd1, 4'b0000}) begin
            fails++;
            $display("FAIL single_offer got=%b/%h/%b/%0d/%b exp=1/ffeeddcc/0111/1/0000",
                     ins_valid, ins_header, ins_keep, grant_id, req_ready);
        end
        tick();
        checks++;
        if ({ins_valid, busy} !== 2'b01) begin
            fails++;
            $display("FAIL single_busy got=%b%b exp=01", ins_valid, busy);
        end
        mon_valid = 1'b1;
        mon_ready = 1'b1;
        for (int b = 1; b <= 5; b++) begin
            mon_last = (b == 5);
            tick();
            if (b < 5) begin
                checks++;
                if ({busy, pkt_cnt} !== {1'b1, 16'd0}) begin
                    fails++;
                    $display("FAIL single_beat%0d got=%b/%0d exp=1/0", b, busy, pkt_cnt);
                end
            end
        end
        mon_valid = 1'b0;
        mon_last  = 1'b0;
        checks++;
        if ({busy, pkt_cnt} !== {1'b0, 16'd1}) begin
            fails++;
            $display("FAIL single_done got=%b/%0d exp=0/1", busy, pkt_cnt);
        end
        // Rotated pointer is 2: with requesters 0,1,2 pending, 2 must win.
        req_valid = 4'b0111;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL single_next_ptr got=%b exp=0100", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_back_to_back();
        int           order [5] = '{0, 1, 2, 3, 0};
        int           g;
        logic [NR-1:0] exp_rr;
        do_reset();
        for (int i = 0; i < NR; i++) set_hdr(i, 32'h1000_0000 + i, 4'hF);
        req_valid = 4'hF;
        ins_ready = 1'b1;
        for (int p = 0; p < 5; p++) begin
            g      = order[p];
            exp_rr = 4'b0001 << g;
            #1;
            checks++;
            if ({req_ready, busy} !== {exp_rr, (p != 0)}) begin
                fails++;
                $display("FAIL b2b_grant%0d got=%b/%b exp=%b/%b", p, req_ready, busy,
                         exp_rr, (p != 0));
            end
            tick();
            mon_valid = 1'b0;
            mon_last  = 1'b0;
            checks++;
            if ({ins_valid, ins_header, grant_id, pkt_cnt} !==
                {1'b1, 32'h1000_0000 + g, 2'(g), 16'(p)}) begin
                fails++;
                $display("FAIL b2b_offer%0d got=%b/%h/%0d/%0d exp=1/%h/%0d/%0d", p, ins_valid,
                         ins_header, grant_id, pkt_cnt, 32'h1000_0000 + g, g, p);
            end
            if (p == 4) break;
            tick();
            checks++;
            if ({ins_valid, busy} !== 2'b01) begin
                fails++;
                $display("FAIL b2b_busy%0d got=%b%b exp=01", p, ins_valid, busy);
            end
            mon_valid = 1'b1;
            mon_ready = 1'b1;
            mon_last  = 1'b0;
            tick();
            mon_last = 1'b1;
        end
        req_valid = '0;
    endtask

    task automatic test_offer_stall();
        do_reset();
        set_hdr(0, 32'hA5A5_0001, 4'b0000);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            ins_ready = (c == 3);
            #1;
            checks++;
            if ({ins_valid, ins_header, ins_keep, busy} !== {1'b1, 32'hA5A5_0001, 4'b0000, 1'b1})
            begin
                fails++;
                $display("FAIL stall_offer%0d got=%b/%h/%b/%b exp=1/a5a50001/0000/1", c,
                         ins_valid, ins_header, ins_keep, busy);
            end
            tick();
        end
        ins_ready = 1'b0;
        checks++;
        if ({ins_valid, busy} !== 2'b01) begin
            fails++;
            $display("FAIL stall_to_busy got=%b%b exp=01", ins_valid, busy);
        end
    endtask

    // Continues from the BUSY state left by test_offer_stall.
    task automatic test_busy_stall();
        mon_valid = 1'b1;
        mon_last  = 1'b1;
        mon_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({busy, ins_valid, pkt_cnt} !== {1'b1, 1'b0, 16'd0}) begin
                fails++;
                $display("FAIL busy_stall%0d got=%b/%b/%0d exp=1/0/0", c, busy, ins_valid,
                         pkt_cnt);
            end
        end
        mon_ready = 1'b1;
        tick();
        mon_valid = 1'b0;
        mon_last  = 1'b0;
        checks++;
        if ({busy, pkt_cnt, err_orphan_last} !== {1'b0, 16'd1, 1'b0}) begin
            fails++;
            $display("FAIL busy_release got=%b/%0d/%b exp=0/1/0", busy, pkt_cnt,
                     err_orphan_last);
        end
    endtask

    task automatic test_orphan();
        do_reset();
        mon_valid = 1'b1;
        mon_ready = 1'b1;
        mon_last  = 1'b1;
        tick();
        mon_valid = 1'b0;
        mon_last  = 1'b0;
        checks++;
        if ({err_orphan_last, pkt_cnt, busy} !== {1'b1, 16'd0, 1'b0}) begin
            fails++;
            $display("FAIL orphan_set got=%b/%0d/%b exp=1/0/0", err_orphan_last, pkt_cnt, busy);
        end
        tick();
        tick();
        checks++;
        if (err_orphan_last !== 1'b1) begin
            fails++;
            $display("FAIL orphan_sticky got=%b exp=1", err_orphan_last);
        end
    endtask

    task automatic test_reset_mid();
        int seq [4] = '{0, 1, 3, 2};
        logic [NR+1+DW+BW+IW+1+CW+1-1:0] outs;
        do_reset();
        ins_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 4'b0001 << seq[i];
            tick();
            req_valid = '0;
            tick();
            if (i == 3) break;
            mon_valid = 1'b1;
            mon_ready = 1'b1;
            mon_last  = 1'b1;
            tick();
            mon_valid = 1'b0;
            mon_ready = 1'b0;
            mon_last  = 1'b0;
        end
        checks++;
        if ({busy, grant_id, pkt_cnt} !== {1'b1, 2'd2, 16'd3}) begin
            fails++;
            $display("FAIL rstmid_pre got=%b/%0d/%0d exp=1/2/3", busy, grant_id, pkt_cnt);
        end
        req_valid = 4'b1000;
        #2;
        rst = 1'b1;
        #1;
        outs = {req_ready, ins_valid, ins_header, ins_keep, grant_id, busy, pkt_cnt,
                err_orphan_last};
        checks++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL rstmid_async got=%0h exp=0", outs);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, busy} !== {4'b1000, 1'b0}) begin
            fails++;
            $display("FAIL rstmid_grant got=%b/%b exp=1000/0", req_ready, busy);
        end
        tick();
        req_valid = '0;
        checks++;
        if ({ins_valid, grant_id, pkt_cnt} !== {1'b1, 2'd3, 16'd0}) begin
            fails++;
            $display("FAIL rstmid_offer got=%b/%0d/%0d exp=1/3/0", ins_valid, grant_id, pkt_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_offer_stall();
        test_busy_stall();
        test_orphan();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/axis_header_insert_arbiter.md
Name: axis_header_insert_arbiter

Overview:
Round-robin scheduler that shares the single header-insert port of the AXI-Stream header inserter between NUM_REQ header requesters. It grants exactly one header per packet and holds that grant until the inserter's output stream completes the packet (last beat handshake). It then rotates priority.
It sits between the header sources and the inserter's valid_insert/header_insert/keep_insert/ready_insert port, and taps the inserter's output handshake.

Parameters:
DATA_WD, 32, header/data width in bits
DATA_BYTE_WD, DATA_WD/8, keep width
NUM_REQ, 4, number of header requesters (>=2)
ID_WD, $clog2(NUM_REQ), grant index width
CNT_WD, 16, completed-packet counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester header valid
req_header  in  NUM_REQ*DATA_WD  packed headers, requester i at [i*DATA_WD +: DATA_WD]
req_keep  in  NUM_REQ*DATA_BYTE_WD  packed keep_insert values
req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
ins_valid  out  1  to inserter valid_insert
ins_header  out  DATA_WD  to inserter header_insert
ins_keep  out  DATA_BYTE_WD  to inserter keep_insert
ins_ready  in  1  from inserter ready_insert
mon_valid  in  1  tap of inserter valid_out
mon_ready  in  1  tap of downstream ready_out
mon_last  in  1  tap of inserter last_out
grant_id  out  ID_WD  index of current/last granted requester
busy  out  1  high in OFFER or BUSY
pkt_cnt  out  CNT_WD  completed packets, wraps modulo 2^CNT_WD
err_orphan_last  out  1  sticky: last handshake seen while not in BUSY

Behaviour:
- Reset (async, rst=1): state IDLE, ptr=0. All outputs are 0: req_ready, ins_valid, ins_header, ins_keep, grant_id, busy, pkt_cnt, err_orphan_last. Reset mid-packet abandons the grant. The inserter is reset by its own logic.
- Arbitration: among set req_valid bits, search upward from ptr with wrap, and pick the first set bit. Fully combinational in the grant cycle.
- States: IDLE, OFFER, BUSY.
- IDLE: if any req_valid, grant winner g in the same cycle:
  - pulse req_ready[g] for one cycle;
  - on the clock edge, capture req_header/req_keep of g into ins_header/ins_keep;
  - grant_id<=g; go to OFFER.
  - Latency req_valid -> ins_valid = 1 cycle. A requester must drop or replace its header after the req_ready pulse.
- OFFER: ins_valid=1. ins_header/ins_keep are stable registered values. On ins_valid&ins_ready, go to BUSY and drop ins_valid the next cycle. If ins_ready stays low, hold indefinitely with no change.
- BUSY: ins_valid=0. Wait for mon_valid&mon_ready&mon_last. On that cycle:
  - pkt_cnt++;
  - ptr<=(grant_id+1) mod NUM_REQ;
  - if any req_valid, arbitrate immediately using the rotated pointer (grant_id+1) in the same cycle, pulse req_ready, capture, and go to OFFER. This gives back-to-back packets with no idle cycle.
  - otherwise go to IDLE.
- Non-last beats in BUSY are ignored (counted by no one).
- mon handshake with mon_last=1 while in IDLE or OFFER: set err_orphan_last (cleared only by reset). No count, no state change.
- ins_keep is forwarded unmodified, including 4'b0000. The arbiter does not interpret keep.
- busy = (state!=IDLE).
- A requester deasserting req_valid while not granted is allowed. Its assertion has no lasting effect.

Test Plan:
- NUM_REQ=4, ptr=0; only req 1 valid with header 32'hFFEE_DDCC, keep 4'b0111 at cycle t; ins_ready=1; 5-beat packet (last on 5th, mon_ready=1) -> req_ready[1] pulses at t; at t+1 ins_valid=1, ins_header=FFEE_DDCC, ins_keep=0111, grant_id=1; BUSY until last handshake; then IDLE, pkt_cnt=1, next ptr=2.
- All four req_valid held high, headers 32'h1000_0000+i, 2-beat packets -> grants in order 0,1,2,3,0. Each new req_ready pulse occurs in the same cycle as the previous last handshake. busy never drops; pkt_cnt=4 after 4 packets.
- In OFFER, ins_ready=0 for 3 cycles then 1 -> ins_valid, ins_header and ins_keep stay constant for 4 cycles. BUSY is entered only after the handshake.
- In BUSY, last beat presented with mon_ready=0 for 2 cycles -> stays BUSY, pkt_cnt unchanged. Advances on the cycle mon_ready=1.
- mon_valid=mon_ready=mon_last=1 while IDLE -> err_orphan_last=1 and stays 1; pkt_cnt unchanged; state IDLE.
- rst pulsed high mid-BUSY (grant_id=2, pkt_cnt=3) -> all outputs 0 immediately, without waiting for a clock edge. After release with req 3 valid, req 3 is granted only after req 0..2 are checked from ptr=0. pkt_cnt=0.
